// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared definitions for the multiply-accumulate issue/writeback
// controller. It holds the request opcode encoding, the in-flight tag record and
// the decode helpers used by mac_ctrl and mac_tag_pipe.
package mac_ctrl_pkg;

  // Datapath latencies in unpaused cycles: issue to vldout and issue to vhdout.
  localparam int unsigned PIPE_LO = 1;
  localparam int unsigned PIPE_HI = 2;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MACL   = 3'd4,
    OP_MACH   = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } op_e;

  typedef struct packed {
    logic       valid;
    logic       hi;
    logic [4:0] rd;
  } tag_t;

  function automatic logic is_valid_op(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MACL, OP_MACH};
  endfunction

  function automatic logic is_hi(op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_MACH};
  endfunction

  function automatic logic is_lo(op_e op);
    return op inside {OP_MUL, OP_MACL};
  endfunction

  // Ops that replace the accumulator rather than add into it.
  function automatic logic is_mul(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic rs1_signed(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MACL, OP_MACH};
  endfunction

  function automatic logic rs2_signed(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MACL, OP_MACH};
  endfunction

  // 33-bit operand: sign- or zero-extension of a 32-bit register value.
  function automatic logic [32:0] extend33(logic [31:0] v, logic sgn);
    return {sgn & v[31], v};
  endfunction

  // One-hot destination of a valid tag; x0 never counts as pending.
  function automatic logic [31:0] rd_onehot(tag_t t);
    logic [31:0] m;
    m = '0;
    if (t.valid) m[t.rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// mac_tag_pipe: two-stage destination-tag pipeline that shadows the mac
// datapath. Stage 1 holds the op issued on the previous unpaused cycle; only
// high-result entries move on to stage 2, low entries retire from stage 1.
// Ports:
//   clk, reset       core clock, synchronous active-high reset
//   pause            global stall, holds both stages
//   i_issue          tag of the op issued this cycle (valid=0 when none)
//   o_s1, o_s2       current stage contents
//   o_pend_mask      one-hot set of destinations in flight (x0 excluded)
//   o_busy           any stage valid
module mac_tag_pipe
  import mac_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  tag_t        i_issue,
  output tag_t        o_s1,
  output tag_t        o_s2,
  output logic [31:0] o_pend_mask,
  output logic        o_busy
);

  tag_t r_s1;
  tag_t r_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else if (!pause) begin
      r_s1 <= i_issue;
      r_s2 <= (r_s1.valid && r_s1.hi) ? r_s1 : '0;
    end
  end

  always_comb begin
    o_s1        = r_s1;
    o_s2        = r_s2;
    o_pend_mask = rd_onehot(r_s1) | rd_onehot(r_s2);
    o_busy      = r_s1.valid | r_s2.valid;
  end

endmodule

// File: rtl/mac_ctrl.sv
// mac_ctrl: issue and writeback controller for the three-stage 33x33 mac
// datapath. Decodes one M-extension/accumulate request per cycle into the mac
// strobes and extended operands, tracks destination tags, blocks the
// low-after-high result port collision and registers one writeback per op.
// Ports:
//   clk, reset, pause                       clock, sync reset, global stall
//   req_valid/req_ready, req_op, req_rs1,
//   req_rs2, req_rd                         request handshake from decode
//   mul_en, mac_low, mac_high, din1, din2   datapath controls (accept cycle only)
//   dlout, dhout, vldout, vhdout            datapath results and strobes
//   wb_valid, wb_rd, wb_data                registered writeback
//   pend_mask, busy                         in-flight destinations / activity
module mac_ctrl
  import mac_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic        mul_en,
  output logic        mac_low,
  output logic        mac_high,
  output logic [32:0] din1,
  output logic [32:0] din2,
  input  logic [31:0] dlout,
  input  logic [31:0] dhout,
  input  logic        vldout,
  input  logic        vhdout,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] pend_mask,
  output logic        busy
);

  op_e         w_op;
  logic        w_accept;
  logic        w_go;
  tag_t        w_issue;
  tag_t        w_s1;
  tag_t        w_s2;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  assign w_op = op_e'(req_op);

  always_comb begin
    // A low op issued right behind a high op would land on vldout in the same
    // cycle the high op reaches vhdout, so it waits one cycle.
    req_ready = !reset && !pause && !(w_s1.valid && w_s1.hi && is_lo(w_op));
    w_accept  = req_valid && req_ready;
    // Reserved ops are consumed without touching the datapath or the tags.
    w_go      = w_accept && is_valid_op(w_op);
    mul_en    = w_go && is_mul(w_op);
    mac_low   = w_go && is_lo(w_op);
    mac_high  = w_go && is_hi(w_op);
    din1      = w_go ? extend33(req_rs1, rs1_signed(w_op)) : '0;
    din2      = w_go ? extend33(req_rs2, rs2_signed(w_op)) : '0;
    w_issue   = '{valid: w_go, hi: w_go && is_hi(w_op), rd: req_rd};
  end

  mac_tag_pipe u_tag_pipe (
    .clk         (clk),
    .reset       (reset),
    .pause       (pause),
    .i_issue     (w_issue),
    .o_s1        (w_s1),
    .o_s2        (w_s2),
    .o_pend_mask (pend_mask),
    .o_busy      (busy)
  );

  // Strobes arrive already pause-masked, so the writeback register runs freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= vldout | vhdout;
      r_wb_data  <= vhdout ? dhout : dlout;
      r_wb_rd    <= vhdout ? w_s2.rd : (vldout ? w_s1.rd : '0);
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;

  a_no_dual_strobe: assert property (@(posedge clk) disable iff (reset)
    !(vldout && vhdout));
  a_vld_has_tag: assert property (@(posedge clk) disable iff (reset)
    vldout |-> (w_s1.valid && !w_s1.hi));
  a_vhd_has_tag: assert property (@(posedge clk) disable iff (reset)
    vhdout |-> w_s2.valid);

endmodule

// File: tb/tb_mac_ctrl.sv
module tb_mac_ctrl;
  import mac_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        mul_en, mac_low, mac_high;
  logic [32:0] din1, din2;
  logic [31:0] dlout, dhout;
  logic        vldout, vhdout;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pend_mask;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_ctrl dut (
    .clk(clk), .reset(reset), .pause(pause),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .mul_en(mul_en), .mac_low(mac_low), .mac_high(mac_high),
    .din1(din1), .din2(din2),
    .dlout(dlout), .dhout(dhout), .vldout(vldout), .vhdout(vhdout),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pend_mask(pend_mask), .busy(busy)
  );

  // Behavioural stand-in for the mac datapath: signed 33x33 product into a
  // 66-bit accumulator, low slice one unpaused cycle later, high slice two.
  logic [65:0]        m_acc, m1_val, m2_val, m_next;
  logic               m1_v, m1_hi, m2_v;
  logic signed [65:0] m_prod;
  assign m_prod = $signed(din1) * $signed(din2);
  assign m_next = mul_en ? m_prod : m_acc + m_prod;
  always @(posedge clk) begin
    if (reset) begin
      m_acc <= '0; m1_val <= '0; m2_val <= '0;
      m1_v <= 1'b0; m1_hi <= 1'b0; m2_v <= 1'b0;
    end else if (!pause) begin
      if (mac_low || mac_high) m_acc <= m_next;
      m1_v   <= mac_low || mac_high;
      m1_hi  <= mac_high;
      m1_val <= m_next;
      m2_v   <= m1_v && m1_hi;
      m2_val <= m1_val;
    end
  end
  assign vldout = m1_v && !m1_hi && !pause;
  assign vhdout = m2_v && !pause;
  assign dlout  = m1_val[31:0];
  assign dhout  = m2_val[63:32];

  // Reference model: in-order list of outstanding results, each counting down
  // its remaining unpaused cycles; the result is expected on wb one cycle
  // after its count reaches zero.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cnt;
  } ent_t;
  ent_t        q[$];
  logic [65:0] ref_acc  = '0;
  logic        due      = 1'b0;
  logic [4:0]  due_rd   = '0;
  logic [31:0] due_data = '0;
  logic        last_hi  = 1'b0;

  function automatic logic [65:0] ext66(logic [31:0] v, logic s);
    return s ? {{34{v[31]}}, v} : {34'd0, v};
  endfunction

  always @(negedge clk) begin : monitor
    logic [31:0] ep;
    logic        er, acc_now, lo_op;
    logic [2:0]  ectl;
    logic [65:0] p;
    ent_t        e;
    if (mon_en) begin
      ep = '0;
      foreach (q[i]) if (q[i].rd != 5'd0) ep[q[i].rd] = 1'b1;
      total++;
      if (pend_mask !== ep) begin
        bad++; $display("FAIL mon_pend_mask cyc=%0d got=%h exp=%h", cyc, pend_mask, ep);
      end
      total++;
      if (busy !== (q.size() != 0)) begin
        bad++; $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() != 0);
      end
      total++;
      if (wb_valid !== due || (due && (wb_rd !== due_rd || wb_data !== due_data))) begin
        bad++;
        $display("FAIL mon_wb cyc=%0d got v=%b rd=%0d d=%h exp v=%b rd=%0d d=%h",
                 cyc, wb_valid, wb_rd, wb_data, due, due_rd, due_data);
      end
      lo_op = (req_op == 3'd0) || (req_op == 3'd4);
      er = !reset && !pause && !(last_hi && lo_op);
      total++;
      if (req_ready !== er) begin
        bad++; $display("FAIL mon_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er);
      end
      acc_now = req_valid && req_ready;
      if (!acc_now) begin
        total++;
        if ({mul_en, mac_low, mac_high} !== 3'b000 || din1 !== 33'd0 || din2 !== 33'd0) begin
          bad++;
          $display("FAIL mon_idle_ctl cyc=%0d got ctl=%b d1=%h d2=%h exp ctl=000 d1=0 d2=0",
                   cyc, {mul_en, mac_low, mac_high}, din1, din2);
        end
      end else begin
        ectl = (req_op > 3'd5) ? 3'b000 : {req_op <= 3'd3, lo_op, !lo_op};
        total++;
        if ({mul_en, mac_low, mac_high} !== ectl) begin
          bad++;
          $display("FAIL mon_ctl cyc=%0d op=%0d got=%b exp=%b", cyc, req_op,
                   {mul_en, mac_low, mac_high}, ectl);
        end
      end
      if (reset) begin
        q.delete(); due = 1'b0; last_hi = 1'b0; ref_acc = '0;
      end else begin
        due = 1'b0;
        if (!pause) begin
          foreach (q[i]) q[i].cnt--;
          if (q.size() != 0 && q[0].cnt == 0) begin
            due = 1'b1; due_rd = q[0].rd; due_data = q[0].data;
            void'(q.pop_front());
          end
          last_hi = acc_now && (req_op <= 3'd5) && !lo_op;
          if (acc_now && req_op <= 3'd5) begin
            p = ext66(req_rs1, req_op != 3'd3) *
                ext66(req_rs2, (req_op == 3'd0) || (req_op == 3'd1) || (req_op >= 3'd4));
            ref_acc = (req_op <= 3'd3) ? p : ref_acc + p;
            e.rd   = req_rd;
            e.data = lo_op ? ref_acc[31:0] : ref_acc[63:32];
            e.cnt  = lo_op ? int'(PIPE_LO) : int'(PIPE_HI);
            q.push_back(e);
          end
        end
      end
    end
  end

  // Stimulus helpers (called at 1 time unit after a rising edge).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int t, output int waits);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout op=%0d rd=%0d got=no_accept exp=accept", op, rd);
    end
    t = cyc;
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'h1234; req_rs2 = 32'h5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    total++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      bad++; $display("FAIL rst_wb got v=%b rd=%0d d=%h exp v=0 rd=0 d=0", wb_valid, wb_rd, wb_data);
    end
    total++;
    if (pend_mask !== 32'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_pend got mask=%h busy=%b exp mask=0 busy=0", pend_mask, busy);
    end
    total++;
    if ({mul_en, mac_low, mac_high} !== 3'b000 || din1 !== 33'd0 || din2 !== 33'd0) begin
      bad++; $display("FAIL rst_datapath got ctl=%b d1=%h d2=%h exp 0", {mul_en, mac_low, mac_high}, din1, din2);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    mon_en = 1'b1;
    idle(1);
  endtask

  task automatic test_products();
    logic [2:0]  ops[4] = '{3'd3, 3'd0, 3'd1, 3'd2};
    logic [31:0] as[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] exps[4] = '{32'hFFFFFFFE, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    logic [4:0]  rds[4] = '{5'd5, 5'd5, 5'd11, 5'd12};
    int t, w, lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], 32'hFFFFFFFF, rds[i], t, w);
      req_valid = 1'b0;
      lat = (ops[i] == 3'd0) ? 2 : 3;
      wait_cyc(t + lat - 1);
      total++;
      if (wb_valid !== 1'b0) begin
        bad++; $display("FAIL prod_early op=%0d got wb_valid=%b exp=0", ops[i], wb_valid);
      end
      wait_cyc(t + lat);
      total++;
      if (wb_valid !== 1'b1 || wb_rd !== rds[i] || wb_data !== exps[i]) begin
        bad++;
        $display("FAIL prod op=%0d got v=%b rd=%0d d=%h exp v=1 rd=%0d d=%h",
                 ops[i], wb_valid, wb_rd, wb_data, rds[i], exps[i]);
      end
      @(posedge clk); #1;
      idle(2);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, w;
    issue(3'd0, 32'd3, 32'd4, 5'd1, t1, w);
    issue(3'd4, 32'd5, 32'd6, 5'd2, t2, w);
    req_valid = 1'b0;
    total++;
    if (t2 !== t1 + 1) begin bad++; $display("FAIL b2b_bubble got=%0d exp=%0d", t2, t1 + 1); end
    wait_cyc(t1 + 2);
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'd12) begin
      bad++; $display("FAIL b2b_mul got v=%b rd=%0d d=%h exp v=1 rd=1 d=c", wb_valid, wb_rd, wb_data);
    end
    wait_cyc(t1 + 3);
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'd42) begin
      bad++; $display("FAIL b2b_macl got v=%b rd=%0d d=%h exp v=1 rd=2 d=2a", wb_valid, wb_rd, wb_data);
    end
    @(posedge clk); #1;
    idle(3);
  endtask

  task automatic test_hazard();
    int t1, t2, w1, w2;
    issue(3'd1, 32'h40000000, 32'h10, 5'd3, t1, w1);
    issue(3'd0, 32'h1234, 32'h10, 5'd4, t2, w2);
    req_valid = 1'b0;
    total++;
    if (w2 !== 1 || t2 !== t1 + 2) begin
      bad++; $display("FAIL hazard_stall got waits=%0d dt=%0d exp waits=1 dt=2", w2, t2 - t1);
    end
    wait_cyc(t1 + 3);
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd4) begin
      bad++; $display("FAIL hazard_hi got v=%b rd=%0d d=%h exp v=1 rd=3 d=4", wb_valid, wb_rd, wb_data);
    end
    wait_cyc(t1 + 4);
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h12340) begin
      bad++; $display("FAIL hazard_lo got v=%b rd=%0d d=%h exp v=1 rd=4 d=12340", wb_valid, wb_rd, wb_data);
    end
    @(posedge clk); #1;
    idle(3);
  endtask

  task automatic test_pause();
    int t0, t, w;
    issue(3'd0, 32'h10000, 32'h10000, 5'd6, t0, w);
    issue(3'd5, 32'h10000, 32'h30000, 5'd7, t, w);
    req_valid = 1'b0;
    pause = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(t + k);
      total++;
      if (pend_mask !== 32'h80 || busy !== 1'b1) begin
        bad++; $display("FAIL pause_hold k=%0d got mask=%h busy=%b exp mask=80 busy=1", k, pend_mask, busy);
      end
      if (k == 1) begin
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 32'd0) begin
          bad++; $display("FAIL pause_mul_wb got v=%b rd=%0d d=%h exp v=1 rd=6 d=0", wb_valid, wb_rd, wb_data);
        end
      end
    end
    @(posedge clk); #1;
    pause = 1'b0;
    wait_cyc(t + 5);
    total++;
    if (wb_valid !== 1'b0 || pend_mask !== 32'h80) begin
      bad++; $display("FAIL pause_pre_wb got v=%b mask=%h exp v=0 mask=80", wb_valid, pend_mask);
    end
    wait_cyc(t + 6);
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'd4 || busy !== 1'b0 || pend_mask !== 32'd0) begin
      bad++;
      $display("FAIL pause_wb got v=%b rd=%0d d=%h busy=%b mask=%h exp v=1 rd=7 d=4 busy=0 mask=0",
               wb_valid, wb_rd, wb_data, busy, pend_mask);
    end
    @(posedge clk); #1;
    idle(3);
  endtask

  task automatic test_reset_midflight();
    int t, t2, w;
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, t, w);
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_cyc(t + 3 + k);
      total++;
      if (wb_valid !== 1'b0 || pend_mask !== 32'd0 || busy !== 1'b0) begin
        bad++; $display("FAIL rst_flight k=%0d got v=%b mask=%h busy=%b exp v=0 mask=0 busy=0",
                        k, wb_valid, pend_mask, busy);
      end
    end
    @(posedge clk); #1;
    issue(3'd0, 32'd7, 32'd9, 5'd10, t2, w);
    req_valid = 1'b0;
    wait_cyc(t2 + 2);
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd10 || wb_data !== 32'd63) begin
      bad++; $display("FAIL rst_after_mul got v=%b rd=%0d d=%h exp v=1 rd=10 d=3f", wb_valid, wb_rd, wb_data);
    end
    @(posedge clk); #1;
    idle(2);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'hFFFFFFFF;
      1: return 32'h80000000;
      2: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic accepted = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      pause = ($urandom_range(0, 9) < 2);
      if (!req_valid || accepted) begin
        if ($urandom_range(0, 3) != 0) begin
          req_valid = 1'b1;
          req_op  = 3'($urandom_range(0, 7));
          req_rs1 = rand_operand();
          req_rs2 = rand_operand();
          req_rd  = 5'($urandom_range(0, 31));
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      accepted = req_valid && req_ready;
      @(posedge clk); #1;
    end
    pause = 1'b0;
    idle(6);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || pend_mask !== 32'd0) begin
      bad++; $display("FAIL rand_drain got busy=%b mask=%h exp busy=0 mask=0", busy, pend_mask);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_products();
    test_back_to_back();
    test_hazard();
    test_pause();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mac_ctrl.md
# mac_ctrl

Issue and writeback controller for the three-stage 33×33 multiply-accumulate datapath (`mac`) in the core's execute stage. Accepts one M-extension or accumulate request per cycle from decode via valid/ready, and forms the sign/zero-extended 33-bit operands. Drives `mul_en`/`mac_low`/`mac_high`, tracks destination tags alongside the datapath pipeline, and resolves the low/high result-port collision. Returns one registered writeback per request to the register file.

## Interface
- `PIPE_LO`, 1: datapath latency, issue to `vldout`, in unpaused cycles.
- `PIPE_HI`, 2: datapath latency, issue to `vhdout`.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high. Shared with `mac`.
- `pause` in 1: global stall. Freezes the tag pipeline exactly as it freezes `mac`.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when `req_valid & req_ready`.
- `req_op` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MACL, 5 MACH, 6/7 reserved.
- `req_rs1`, `req_rs2` in 32: operand values.
- `req_rd` in 5: destination register.
- `mul_en`, `mac_low`, `mac_high` out 1: datapath controls, asserted only in the accept cycle.
- `din1`, `din2` out 33: extended operands. Zero when not accepting.
- `dlout`, `dhout` in 32: datapath low/high results.
- `vldout`, `vhdout` in 1: datapath result strobes (already pause-masked).
- `wb_valid` out 1, `wb_rd` out 5, `wb_data` out 32: registered writeback.
- `pend_mask` out 32: one-hot set of rd values in flight (bit 0 always 0).
- `busy` out 1: any tag in flight.

## Operation
- Control decode:
  - Ops 0-3: `mul_en=1`. Product replaces the 66-bit accumulator.
  - Ops 4-5: `mul_en=0`. Accumulator += rs1×rs2.
  - `mac_low` for ops 0 and 4. `mac_high` for ops 1, 2, 3, 5.
- Extension:
  - `din1` is signed (`{rs1[31],rs1}`) for ops 0, 1, 2, 4, 5; otherwise zero-extended.
  - `din2` is signed for ops 0, 1, 4, 5; otherwise zero-extended.
- Reserved ops: accepted when ready, no datapath strobe, no tag, no writeback.
- Tag pipeline:
  - Stage 1 holds {valid, hi, rd} of the op accepted on the previous unpaused cycle.
  - Stage 2 holds a stage-1 entry with hi=1. Low entries retire out of stage 1.
  - Both stages advance only when `!pause`.
- Structural hazard: `req_ready = !pause & !(stage1.valid & stage1.hi & op∈{0,4})`. This blocks a low-result op from issuing the cycle after a high-result op, so `vldout` and `vhdout` never coincide.
- Writeback register, updated every cycle regardless of `pause`:
  - `wb_valid <= vldout | vhdout`.
  - `wb_data <= vhdout ? dhout : dlout`.
  - `wb_rd <= ` tag of the retiring stage.
- `pend_mask`: OR of one-hot rd of valid stage-1 and stage-2 entries, with rd=0 masked.
- `busy`: stage1.valid | stage2.valid.
- Reset: all tags invalid. `wb_valid=0`, `wb_rd=0`, `wb_data=0`, `pend_mask=0`, `busy=0`, `req_ready=0` while `reset` is high. Datapath outputs are 0.

## Timing
- Accept at unpaused cycle t:
  - Low op: `vldout` at t+1, `wb_valid` at t+2.
  - High op: `vhdout` at t+2, `wb_valid` at t+3.
- Pause cycles in between extend the latency 1:1. Each result is written back exactly once.
- Back-to-back accumulates issue every cycle with no bubble. The datapath forwards partial accumulator slices internally.
- A high op followed by a low op inserts exactly one bubble. A low op followed by a high op has no bubble.
- Throughput: one request per cycle except the hazard case above.
- Assertion: `vldout & vhdout` never true. `vldout` requires stage1.valid & !hi. `vhdout` requires stage2.valid.
- Reset mid-flight drops all in-flight tags. No writeback follows.

## Structure
- Package `mac_ctrl_pkg`:
  - op encodings and `is_hi(op)`, `is_mul(op)`, `rs1_signed(op)`, `rs2_signed(op)` functions.
  - tag struct {valid, hi, rd[4:0]}.
- One sub-module, `mac_tag_pipe`: the two-stage tag pipeline with pause hold and the pend_mask/busy derivation.
- `mac_ctrl` instantiates `mac_tag_pipe` only. `mac` is instantiated beside it in execute.

## Test plan
- MULHU, rs1=rs2=0xFFFFFFFF, rd=5 -> wb_valid at t+3, wb_rd=5, wb_data=0xFFFFFFFE. MUL of the same operands -> 0x00000001 at t+2.
- MULH 0x80000000×0xFFFFFFFF -> 0x00000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- MUL 3×4 (rd=1), then MACL 5×6 on the next cycle (rd=2) -> wb 12 at t+2 and 42 at t+3, no bubble.
- MULH (rd=3) with MUL (rd=4) pending behind it -> req_ready=0 for one cycle. MUL accepted at t+2. Writebacks at t+3 (rd=3) and t+4 (rd=4). Never a dual strobe.
- MACH issued, then pause held for 3 cycles at t+1 -> pend_mask holds its rd bit. Single wb appears 3 cycles late, and busy clears after it.
- Reset asserted the cycle after a MULHU issue -> no wb_valid follows, pend_mask=0, busy=0. The next MUL after reset produces the correct product.
